// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache controller.
package icache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StFill
  } state_e;

  localparam logic [31:0] Nop = 32'h0000_0013;

  localparam int unsigned DefaultLines        = 64;
  localparam int unsigned DefaultWordsPerLine = 4;

endpackage

// File: rtl/icache_ram.sv
// Instruction cache data array: one-word synchronous write, asynchronous read.
module icache_ram
  import icache_pkg::*;
#(
  parameter int unsigned LINES          = DefaultLines,
  parameter int unsigned WORDS_PER_LINE = DefaultWordsPerLine
) (
  input  logic                                      clk_i,
  input  logic                                      we_i,
  input  logic [$clog2(LINES*WORDS_PER_LINE)-1:0]   waddr_i,
  input  logic [31:0]                               wdata_i,
  input  logic [$clog2(LINES*WORDS_PER_LINE)-1:0]   raddr_i,
  output logic [31:0]                               rdata_o
);

  localparam int unsigned Depth = LINES * WORDS_PER_LINE;

  logic [31:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: combinational hit path, single
// outstanding line refill over a request/beat memory channel.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned LINES          = DefaultLines,
  parameter int unsigned WORDS_PER_LINE = DefaultWordsPerLine
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] address_i,
  output logic [31:0] rd_data_o,
  output logic        stall_o,
  input  logic        flush_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_addr_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i
);

  localparam int unsigned WordW = $clog2(WORDS_PER_LINE);
  localparam int unsigned IdxW  = $clog2(LINES);
  localparam int unsigned OffW  = WordW + 2;
  localparam int unsigned TagW  = 32 - OffW - IdxW;
  localparam logic [WordW-1:0] LastBeat = WordW'(WORDS_PER_LINE - 1);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [WordW-1:0] cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic             req_valid_q, req_valid_d;

  logic [TagW-1:0]  tag_mem [LINES];

  logic [IdxW-1:0]  lk_idx, fill_idx;
  logic [WordW-1:0] lk_word;
  logic [TagW-1:0]  lk_tag, fill_tag;
  logic             lk_hit;
  logic             ram_we, tag_we;
  logic [31:0]      ram_rdata;
  logic             unused_addr_bits;

  assign lk_word  = address_i[2 +: WordW];
  assign lk_idx   = address_i[OffW +: IdxW];
  assign lk_tag   = address_i[31 -: TagW];
  assign fill_idx = addr_q[OffW +: IdxW];
  assign fill_tag = addr_q[31 -: TagW];

  assign unused_addr_bits = ^address_i[1:0];

  assign lk_hit = (state_q == StIdle) && valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    req_valid_d  = req_valid_q;
    ram_we       = 1'b0;
    tag_we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Lookup above already used the pre-flush valid bits.
        if (flush_i) valid_d = '0;
        if (!lk_hit) begin
          state_d     = StReq;
          addr_d      = {address_i[31:OffW], {OffW{1'b0}}};
          req_valid_d = 1'b1;
        end
      end
      StReq: begin
        flush_pend_d = flush_pend_q | flush_i;
        if (mem_req_ready_i) begin
          state_d     = StFill;
          cnt_d       = '0;
          req_valid_d = 1'b0;
        end
      end
      StFill: begin
        flush_pend_d = flush_pend_q | flush_i;
        if (mem_rsp_valid_i && !reset_i) begin
          ram_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LastBeat) begin
            tag_we       = 1'b1;
            state_d      = StIdle;
            cnt_d        = '0;
            flush_pend_d = 1'b0;
            // A flush seen during the refill also discards the line just fetched.
            if (flush_pend_q || flush_i) begin
              valid_d = '0;
            end else begin
              valid_d[fill_idx] = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      req_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      req_valid_q  <= req_valid_d;
    end
    addr_q <= addr_d;
  end

  always_ff @(posedge clk_i) begin
    if (tag_we) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

  icache_ram #(
    .LINES         (LINES),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .waddr_i({fill_idx, cnt_q}),
    .wdata_i(mem_rsp_data_i),
    .raddr_i({lk_idx, lk_word}),
    .rdata_o(ram_rdata)
  );

  assign stall_o         = reset_i | ~lk_hit;
  assign rd_data_o       = stall_o ? Nop : ram_rdata;
  assign mem_req_valid_o = req_valid_q;
  assign mem_req_addr_o  = addr_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: a line-level cache model checked every cycle,
// plus literal expectations for the refill protocol, flush and reset cases.
module tb_icache_ctrl;

  localparam int unsigned Lines     = 64;
  localparam int unsigned Wpl       = 4;
  localparam int unsigned LineBytes = Wpl * 4;
  localparam logic [31:0] NopW      = 32'h0000_0013;

  logic        clk_i           = 1'b0;
  logic        reset_i         = 1'b1;
  logic [31:0] address_i       = 32'h0;
  logic        flush_i         = 1'b0;
  logic        mem_req_ready_i = 1'b0;
  logic        mem_rsp_valid_i = 1'b0;
  logic [31:0] mem_rsp_data_i  = 32'h0;
  logic [31:0] rd_data_o;
  logic        stall_o;
  logic        mem_req_valid_o;
  logic [31:0] mem_req_addr_o;

  int vectors     = 0;
  int miscompares = 0;
  int stall_cnt   = 0;
  bit chk_en      = 1'b0;

  // Model: which line address each index currently holds, plus refill progress.
  int unsigned slot [int unsigned];
  bit          m_req   = 1'b0;
  bit          m_fill  = 1'b0;
  bit          m_fpend = 1'b0;
  int          m_beats = 0;
  logic [31:0] m_line  = 32'h0;

  icache_ctrl dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .address_i      (address_i),
    .rd_data_o      (rd_data_o),
    .stall_o        (stall_o),
    .flush_i        (flush_i),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i (mem_rsp_data_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + (a >> 2) - 32'h40;
  endfunction

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a / LineBytes) % Lines;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a - (a % LineBytes);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int unsigned i;
    i = idx_of(a);
    return slot.exists(i) && (slot[i] == line_of(a));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Model update on every active edge.
  initial begin
    forever begin
      bit miss;
      @(posedge clk_i);
      if (reset_i) begin
        slot.delete();
        m_req   = 1'b0;
        m_fill  = 1'b0;
        m_fpend = 1'b0;
        m_beats = 0;
      end else if (m_req) begin
        if (flush_i) m_fpend = 1'b1;
        if (mem_req_ready_i) begin
          m_req   = 1'b0;
          m_fill  = 1'b1;
          m_beats = 0;
        end
      end else if (m_fill) begin
        if (flush_i) m_fpend = 1'b1;
        if (mem_rsp_valid_i) begin
          m_beats++;
          if (m_beats == Wpl) begin
            m_fill = 1'b0;
            if (m_fpend) slot.delete();
            else slot[idx_of(m_line)] = m_line;
            m_fpend = 1'b0;
          end
        end
      end else begin
        miss = !m_hit(address_i);
        if (flush_i) slot.delete();
        if (miss) begin
          m_req  = 1'b1;
          m_line = line_of(address_i);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      logic exp_stall;
      @(negedge clk_i);
      if (chk_en) begin
        exp_stall = reset_i || m_req || m_fill || !m_hit(address_i);
        if (stall_o) stall_cnt++;
        check("cyc_stall", 32'(stall_o), 32'(exp_stall));
        check("cyc_rdata", rd_data_o, exp_stall ? NopW : mem_word(address_i));
        check("cyc_req_valid", 32'(mem_req_valid_o), 32'(m_req));
        if (m_req) check("cyc_req_addr", mem_req_addr_o, m_line);
      end
    end
  end

  task automatic serve(input logic [31:0] exp_addr, input int rdly, input int gap,
                       input int flush_beat, input int abort_beat);
    int n;
    n = 0;
    while (!mem_req_valid_o && n < 20) begin
      step();
      n++;
    end
    if (!mem_req_valid_o) begin
      check("req_timeout", 32'(mem_req_valid_o), 32'd1);
      return;
    end
    for (int i = 0; i < rdly; i++) begin
      check("req_hold_valid", 32'(mem_req_valid_o), 32'd1);
      check("req_hold_addr", mem_req_addr_o, exp_addr);
      step();
    end
    check("req_addr", mem_req_addr_o, exp_addr);
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    for (int b = 0; b < Wpl; b++) begin
      repeat (gap) step();
      if (b == flush_beat) flush_i = 1'b1;
      if (b == abort_beat) reset_i = 1'b1;
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = mem_word(exp_addr + 32'(4 * b));
      step();
      mem_rsp_valid_i = 1'b0;
      flush_i         = 1'b0;
      if (b == abort_beat) begin
        reset_i = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step();
    chk_en = 1'b1;
    step();
    reset_i = 1'b0;

    // Reset state and first request
    check("rst_stall", 32'(stall_o), 32'd1);
    check("rst_nop", rd_data_o, NopW);
    step();
    check("rst_req_valid", 32'(mem_req_valid_o), 32'd1);
    check("rst_req_addr", mem_req_addr_o, 32'h0);
    serve(32'h0, 0, 0, -1, -1);
    check("hit_0", rd_data_o, 32'h60);

    // Minimum miss penalty
    address_i = 32'h104;
    stall_cnt = 0;
    serve(32'h100, 0, 0, -1, -1);
    check("penalty_cycles", 32'(stall_cnt), 32'd6);
    check("hit_104_stall", 32'(stall_o), 32'd0);
    check("hit_104", rd_data_o, 32'hA1);
    address_i = 32'h10C;
    #1;
    check("hit_10c_stall", 32'(stall_o), 32'd0);
    check("hit_10c", rd_data_o, 32'hA3);

    // Conflict eviction, then slow ready and gapped beats on the evicted line
    address_i = 32'h500;
    #1;
    check("evict_miss", 32'(stall_o), 32'd1);
    serve(32'h500, 0, 0, -1, -1);
    check("hit_500", rd_data_o, 32'h1A0);
    address_i = 32'h100;
    #1;
    check("evicted_100_miss", 32'(stall_o), 32'd1);
    serve(32'h100, 5, 2, -1, -1);
    check("slow_hit_100", rd_data_o, 32'hA0);
    address_i = 32'h10C;
    #1;
    check("slow_hit_10c", rd_data_o, 32'hA3);

    // Flush during fill, then flush in idle
    address_i = 32'h200;
    serve(32'h200, 0, 0, 1, -1);
    check("flush_fill_miss", 32'(stall_o), 32'd1);
    serve(32'h200, 0, 0, -1, -1);
    check("hit_200", rd_data_o, 32'hE0);
    address_i = 32'h100;
    serve(32'h100, 0, 0, -1, -1);
    flush_i = 1'b1;
    #1;
    check("flush_idle_pre", 32'(stall_o), 32'd0);
    step();
    flush_i = 1'b0;
    check("flush_idle_post", 32'(stall_o), 32'd1);
    serve(32'h100, 0, 0, -1, -1);

    // Reset on second beat; late beats must be ignored
    address_i = 32'h300;
    serve(32'h300, 0, 0, -1, 1);
    check("abort_stall", 32'(stall_o), 32'd1);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = mem_word(32'h308);
    step();
    mem_rsp_data_i  = mem_word(32'h30C);
    step();
    mem_rsp_valid_i = 1'b0;
    check("rereq_valid", 32'(mem_req_valid_o), 32'd1);
    check("rereq_addr", mem_req_addr_o, 32'h300);
    serve(32'h300, 0, 0, -1, -1);
    check("hit_300", rd_data_o, 32'h120);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL provide parameter LINES, default 64, number of direct-mapped lines (power of two).
REQ-002 SHALL provide parameter WORDS_PER_LINE, default 4, 32-bit words per line (power of two, >= 2).
REQ-003 SHALL provide clk_i  input  1  single clock; all state changes on posedge.
REQ-004 SHALL provide reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL provide address_i  input  32  fetch PC (byte address; bits [1:0] ignored).
REQ-006 SHALL provide rd_data_o  output  32  instruction word for address_i.
REQ-007 SHALL provide stall_o  output  1  high when rd_data_o is not valid; drives the fetch-stage stall.
REQ-008 SHALL provide flush_i  input  1  one-cycle pulse invalidating all lines (fence.i).
REQ-009 SHALL provide mem_req_valid_o  output  1, mem_req_ready_i  input  1, mem_req_addr_o  output  32: line-refill request channel.
REQ-010 SHALL provide mem_rsp_valid_i  input  1, mem_rsp_data_i  input  32: refill data beats, in ascending word order, no backpressure.

Function
REQ-011 Address split (defaults) SHALL be: word = [3:2], index = [9:4], tag = [31:10]; widths derived by $clog2 from parameters.
REQ-012 Hit (state IDLE, valid[index], tag match) SHALL be combinational: rd_data_o = stored word, stall_o = 0, same cycle.
REQ-013 Whenever stall_o = 1, rd_data_o SHALL equal 32'h0000_0013 (NOP).
REQ-014 FSM states SHALL be IDLE, REQ, FILL.
REQ-015 IDLE with miss: stall_o = 1; latch line-aligned address (word and byte bits zero); next state REQ.
REQ-016 REQ: mem_req_valid_o = 1, mem_req_addr_o = latched address, held stable until mem_req_ready_i; on handshake go to FILL with beat counter = 0.
REQ-017 FILL: each mem_rsp_valid_i cycle writes mem_rsp_data_i to word[counter] of latched index, counter increments; on beat WORDS_PER_LINE-1, write tag, set valid, return to IDLE.
REQ-018 mem_rsp_valid_i outside FILL SHALL be ignored; mem_req_valid_o SHALL be 0 outside REQ.
REQ-019 stall_o SHALL be 1 in REQ and FILL regardless of address_i.
REQ-020 Changes of address_i during REQ/FILL SHALL NOT affect the refill; lookup re-evaluates in IDLE after the fill.
REQ-021 Minimum miss penalty (ready and rsp valid every cycle, WORDS_PER_LINE = 4) SHALL be 6 stall cycles; hit on 7th cycle.
REQ-022 flush_i in IDLE SHALL clear all valid bits at the next edge; lookup in the flush cycle uses pre-flush state.
REQ-023 flush_i in REQ/FILL SHALL be recorded; refill completes but its line is left invalid, then all valid bits clear on FILL exit.
REQ-024 Tag/data arrays SHALL NOT be reset; only valid bits are.

Reset
REQ-025 reset_i SHALL force: state IDLE, all valid bits 0, beat counter 0, pending-flush 0, mem_req_valid_o 0.
REQ-026 While reset_i high and in the first cycle after, stall_o SHALL be 1 (all lines invalid) and rd_data_o NOP.
REQ-027 Reset during REQ/FILL SHALL abort the refill; the partly filled line SHALL remain invalid; late beats ignored.

Structure
REQ-028 Shared package icache_pkg SHALL hold the FSM state enum, NOP constant (32'h0000_0013) and default LINES/WORDS_PER_LINE.
REQ-029 One sub-module icache_ram SHALL implement the data array (sync write one word, async read); tags/valid stay in icache_ctrl.

Verification
REQ-030 Reset, address_i = 0x0 -> stall_o = 1, rd_data_o = 0x13, mem_req_valid_o = 1 with mem_req_addr_o = 0x0 one cycle later.
REQ-031 Miss at 0x104, memory returns 0xA0..0xA3 back-to-back, ready = 1 -> stall_o high 6 cycles; then 0x104 returns 0xA1, 0x10C returns 0xA3 with stall_o = 0.
REQ-032 Hold mem_req_ready_i low 5 cycles -> mem_req_valid_o and mem_req_addr_o = 0x100 stable for all 5; beats gapped by 2 idle cycles -> fill still correct.
REQ-033 Fill 0x100, then access 0x500 (same index, different tag) -> miss, refill, 0x100 subsequently misses again.
REQ-034 flush_i pulse during FILL of 0x200 -> fill completes, next 0x200 access misses; flush_i in IDLE -> next cycle previously cached 0x100 misses.
REQ-035 reset_i asserted on second FILL beat -> state IDLE, remaining beats ignored, next access to that line misses and re-requests.
